// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: state encodings and default operand width.
package serial_adder_pkg;

  localparam int DEF_WIDTH = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADD  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_ADD  = ST_ADD,
    S_DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/fa_cell.sv
// Full adder built from two half adders and an OR; the only arithmetic in serial_adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic s1;
  logic c1;
  logic c2;

  ha u_ha0 (.a(a),  .b(b),   .sum(s1),  .carry(c1));
  ha u_ha1 (.a(s1), .b(cin), .sum(sum), .carry(c2));

  // Both half-adder carries can never be high together, so OR is exact.
  assign cout = c1 | c2;

endmodule

// File: rtl/ha.sv
// Half adder: the basic arithmetic cell.
module ha (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one fa_cell processes operands LSB first, one bit per clock.
//
// state   | meaning
// S_IDLE  | waiting for operands; in_ready high
// S_ADD   | shifting one bit per edge through the full adder
// S_DONE  | result held on sum/cout with out_valid until consumed
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic fa_sum;
  logic fa_cout;

  fa_cell u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_cout;
        acc_d   = {fa_sum, acc_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CNT_W'(1);
        // The last bit lands straight in the output registers on the same edge.
        if (cnt_q == CNT_LAST) begin
          sum_d       = {fa_sum, acc_q[WIDTH-1:1]};
          cout_d      = fa_cout;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      acc_q  <= acc_d;
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=8: latency, results, back-pressure, abort and streaming.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
    a        = ta;
    b        = tb;
    cin      = tc;
    in_valid = 1'b1;
    check("accept_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("busy_after_accept", busy, 1);
  endtask

  task automatic wait_result(input string tag, input logic [W-1:0] es, input logic ec);
    int n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, n, W);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, cout, ec);
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    tick();
    check({tag, "_valid_drop"}, out_valid, 0);
    check({tag, "_ready_back"}, in_ready, 1);
    check({tag, "_busy_drop"}, busy, 0);
  endtask

  initial begin
    logic [W-1:0] ra [4];
    logic [W-1:0] rb [4];
    logic         rc [4];
    logic [W:0]   e;
    logic         seen;
    int           n;

    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // T1: reset state
    check("t1_in_ready", in_ready, 1);
    check("t1_out_valid", out_valid, 0);
    check("t1_sum", sum, 0);
    check("t1_cout", cout, 0);
    check("t1_busy", busy, 0);
    tick();
    check("t1_idle_hold", in_ready, 1);

    // T2: basic add
    start_op(8'h0F, 8'h01, 1'b0);
    wait_result("t2", 8'h10, 1'b0);
    consume("t2");

    // T3: overflow cases
    start_op(8'hFF, 8'h01, 1'b0);
    wait_result("t3a", 8'h00, 1'b1);
    consume("t3a");
    start_op(8'hFF, 8'hFF, 1'b1);
    wait_result("t3b", 8'hFF, 1'b1);
    consume("t3b");

    // T4: back-pressure with in_valid toggling
    out_ready = 1'b0;
    start_op(8'h3C, 8'h42, 1'b1);
    wait_result("t4", 8'h7F, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      a        = 8'h11 * 8'(i + 1);
      b        = 8'h22;
      tick();
      check("t4_hold_valid", out_valid, 1);
      check("t4_hold_sum", sum, 8'h7F);
      check("t4_hold_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    consume("t4");
    check("t4_sum_kept_idle", sum, 8'h7F);

    // T5: reset on the 4th bit cycle aborts
    out_ready = 1'b1;
    start_op(8'hAA, 8'h55, 1'b0);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_in_ready", in_ready, 1);
    check("t5_out_valid", out_valid, 0);
    check("t5_sum", sum, 0);
    check("t5_cout", cout, 0);
    check("t5_busy", busy, 0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen = seen | out_valid;
    end
    check("t5_no_stale_valid", seen, 0);
    start_op(8'h12, 8'h34, 1'b0);
    wait_result("t5", 8'h46, 1'b0);
    consume("t5");

    // T6: streaming with in_valid and out_ready held high
    for (int i = 0; i < 4; i++) begin
      ra[i] = W'($urandom);
      rb[i] = W'($urandom);
      rc[i] = 1'($urandom);
    end
    out_ready = 1'b1;
    start_op(ra[0], rb[0], rc[0]);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!out_valid && n < 40) begin
        tick();
        n++;
      end
      e = (W + 1)'(ra[i]) + (W + 1)'(rb[i]) + (W + 1)'(rc[i]);
      check("t6_latency", n, W);
      check("t6_sum", sum, e[W-1:0]);
      check("t6_cout", cout, e[W]);
      if (i < 3) begin
        a   = ra[i+1];
        b   = rb[i+1];
        cin = rc[i+1];
      end else begin
        in_valid = 1'b0;
      end
      tick();
      check("t6_idle", in_ready, 1);
      tick();
      if (i < 3) check("t6_reaccept", busy, 1);
      else       check("t6_stay_idle", busy, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
